// File: rtl/ac_reg_param.sv
// Accumulator (AC) register with E flag for the datapath.
// Single-cycle ops (clear/load/add/and/complement/increment/circulate), plus a
// multi-cycle rotate engine that circulates {E,AC} one bit per clock.
// busy is asserted in the cycle a non-zero rotate is accepted and in every
// ROT cycle after it, so an N-step rotate shows busy for N+1 cycles.
module ac_reg_param #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] acin,
  input  logic             acclr,
  input  logic             acld,
  input  logic             acadd,
  input  logic             acand,
  input  logic             accma,
  input  logic             acinc,
  input  logic             acshr,
  input  logic             acshl,
  input  logic             rot_start,
  input  logic             rot_dir,
  input  logic [CNTW-1:0]  rot_amt,
  output logic [WIDTH-1:0] acout,
  output logic             e_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, ROT} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             done_q, done_d;

  logic             other_op;
  logic             start_ok;
  logic [WIDTH:0]   shr_v, shl_v, sum_v;

  assign other_op = acclr | acld | acadd | acand | accma | acinc | acshr | acshl;
  assign start_ok = (state_q == IDLE) && rot_start && !other_op;

  // One-bit circulates of {E,AC}, right and left.
  assign shr_v = {ac_q[0], e_q, ac_q[WIDTH-1:1]};
  assign shl_v = {ac_q[WIDTH-1], ac_q[WIDTH-2:0], e_q};
  assign sum_v = {1'b0, ac_q} + {1'b0, acin};

  assign acout = ac_q;
  assign e_out = e_q;
  assign zero  = (ac_q == '0);
  assign done  = done_q;
  assign busy  = (state_q == ROT) || (start_ok && (rot_amt != '0));

  // Next-state: prioritised single-cycle ops in IDLE, stepping/abort in ROT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ac_d    = ac_q;
    e_d     = e_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acclr) begin
          ac_d = '0;
          e_d  = 1'b0;
        end else if (acld) begin
          ac_d = acin;
        end else if (acadd) begin
          {e_d, ac_d} = sum_v;
        end else if (acand) begin
          ac_d = ac_q & acin;
        end else if (accma) begin
          ac_d = ~ac_q;
        end else if (acinc) begin
          ac_d = ac_q + WIDTH'(1);
        end else if (acshr) begin
          {e_d, ac_d} = shr_v;
        end else if (acshl) begin
          {e_d, ac_d} = shl_v;
        end else if (rot_start) begin
          if (rot_amt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ROT;
            cnt_d   = rot_amt;
            dir_d   = rot_dir;
          end
        end
      end
      ROT: begin
        if (acclr) begin
          // Abort: clear everything, no done pulse.
          ac_d    = '0;
          e_d     = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          {e_d, ac_d} = dir_q ? shl_v : shr_v;
          cnt_d       = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ac_q    <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ac_reg_param.sv
// Scoreboard bench for ac_reg_param: the driver applies stimulus just after each
// rising edge and pushes the expected per-cycle outputs; the monitor pops and
// compares on the falling edge. The reference model treats {E,AC} as a 17-bit
// value and computes rotates as a modular rotation of the value captured at start.
module tb_ac_reg_param;
  localparam int W = 16;
  localparam int C = 5;

  logic         clk, rst_n;
  logic [W-1:0] acin;
  logic         acclr, acld, acadd, acand, accma, acinc, acshr, acshl;
  logic         rot_start, rot_dir;
  logic [C-1:0] rot_amt;
  logic [W-1:0] acout;
  logic         e_out, zero, busy, done;

  ac_reg_param #(.WIDTH(W), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n), .acin(acin),
    .acclr(acclr), .acld(acld), .acadd(acadd), .acand(acand),
    .accma(accma), .acinc(acinc), .acshr(acshr), .acshl(acshl),
    .rot_start(rot_start), .rot_dir(rot_dir), .rot_amt(rot_amt),
    .acout(acout), .e_out(e_out), .zero(zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] din;
    logic clr, ld, add, an, cma, inc, shr, shl, st, dir;
    logic [C-1:0] amt;
  } stim_t;

  typedef struct packed {
    logic [W-1:0] ac;
    logic e, busy, done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W:0] m_v, m_orig;
  int         m_rem, m_amt;
  logic       m_dir, m_done;

  function automatic logic [W:0] rot(input logic [W:0] v, input int k, input logic left);
    int kk;
    kk = k % (W + 1);
    if (kk == 0) return v;
    if (left) return (v << kk) | (v >> (W + 1 - kk));
    return (v >> kk) | (v << (W + 1 - kk));
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_v = '0; m_orig = '0; m_rem = 0; m_amt = 0; m_dir = 1'b0; m_done = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    exp_t x;
    logic other;
    logic [W-1:0] ac;
    logic e;
    @(posedge clk);
    #1;
    acin = s.din; acclr = s.clr; acld = s.ld; acadd = s.add; acand = s.an;
    accma = s.cma; acinc = s.inc; acshr = s.shr; acshl = s.shl;
    rot_start = s.st; rot_dir = s.dir; rot_amt = s.amt;
    other = s.clr | s.ld | s.add | s.an | s.cma | s.inc | s.shr | s.shl;
    x.ac   = m_v[W-1:0];
    x.e    = m_v[W];
    x.done = m_done;
    x.busy = (m_rem > 0) || (!other && s.st && s.amt != 0);
    q.push_back(x);
    // Advance the model across the coming edge.
    ac = m_v[W-1:0];
    e  = m_v[W];
    if (m_rem > 0) begin
      if (s.clr) begin
        m_v = '0; m_rem = 0; m_done = 1'b0;
      end else begin
        m_rem--;
        m_v = rot(m_orig, m_amt - m_rem, m_dir);
        m_done = (m_rem == 0);
      end
    end else begin
      m_done = 1'b0;
      if (s.clr)       m_v = '0;
      else if (s.ld)   m_v = {e, s.din};
      else if (s.add)  m_v = {1'b0, ac} + {1'b0, s.din};
      else if (s.an)   m_v = {e, ac & s.din};
      else if (s.cma)  m_v = {e, ~ac};
      else if (s.inc)  m_v = {e, ac + 16'd1};
      else if (s.shr)  m_v = rot(m_v, 1, 1'b0);
      else if (s.shl)  m_v = rot(m_v, 1, 1'b1);
      else if (s.st) begin
        if (s.amt == 0) m_done = 1'b1;
        else begin
          m_orig = m_v; m_rem = int'(s.amt); m_amt = int'(s.amt); m_dir = s.dir;
        end
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && q.size() > 0) begin
      x = q.pop_front();
      chk("acout", acout, x.ac);
      chk("e_out", W'(e_out), W'(x.e));
      chk("zero", W'(zero), W'(x.ac == '0));
      chk("busy", W'(busy), W'(x.busy));
      chk("done", W'(done), W'(x.done));
      chk("done_busy_excl", W'(done & busy), '0);
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    acin = '0; acclr = 0; acld = 0; acadd = 0; acand = 0; accma = 0;
    acinc = 0; acshr = 0; acshl = 0; rot_start = 0; rot_dir = 0; rot_amt = '0;
    model_reset();
    #3;
    chk("rst_acout", acout, '0);
    chk("rst_busy", W'(busy), '0);
    #19 rst_n = 1'b1;

    // Load, then load+clear together: clear wins.
    s = idle(); s.ld = 1; s.din = 16'hA5C3; drive(s);
    s.clr = 1; drive(s);
    drive(idle());

    // Add with carry-out, then increment wrap leaving E alone.
    s = idle(); s.ld = 1; s.din = 16'hFFFF; drive(s);
    s = idle(); s.add = 1; s.din = 16'h0001; drive(s);
    s = idle(); s.clr = 1; drive(s);
    s = idle(); s.ld = 1; s.din = 16'hFFFF; drive(s);
    s = idle(); s.inc = 1; drive(s);
    drive(idle());

    // Single-bit circulates through E.
    s = idle(); s.ld = 1; s.din = 16'h8001; drive(s);
    s = idle(); s.shr = 1; drive(s);
    s = idle(); s.clr = 1; drive(s);
    s = idle(); s.ld = 1; s.din = 16'h8001; drive(s);
    s = idle(); s.shl = 1; drive(s);
    drive(idle());

    // Multi-step rotates: 3 left, 17 (full circle), 0.
    s = idle(); s.clr = 1; drive(s);
    s = idle(); s.ld = 1; s.din = 16'h0001; drive(s);
    s = idle(); s.st = 1; s.dir = 1; s.amt = 5'd3; drive(s);
    repeat (5) drive(idle());
    s = idle(); s.st = 1; s.dir = 1; s.amt = 5'd17; drive(s);
    repeat (19) drive(idle());
    s = idle(); s.st = 1; s.amt = 5'd0; drive(s);
    repeat (2) drive(idle());

    // Abort on the 3rd busy cycle; a load mid-rotate is ignored.
    s = idle(); s.ld = 1; s.din = 16'h1234; drive(s);
    s = idle(); s.st = 1; s.amt = 5'd10; drive(s);
    s = idle(); s.ld = 1; s.din = 16'hBEEF; drive(s);
    s = idle(); s.clr = 1; drive(s);
    repeat (3) drive(idle());

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.din = W'($urandom);
      s.clr = ($urandom_range(0, 19) == 0);
      s.ld  = ($urandom_range(0, 9) == 0);
      s.add = ($urandom_range(0, 9) == 0);
      s.an  = ($urandom_range(0, 11) == 0);
      s.cma = ($urandom_range(0, 11) == 0);
      s.inc = ($urandom_range(0, 11) == 0);
      s.shr = ($urandom_range(0, 11) == 0);
      s.shl = ($urandom_range(0, 11) == 0);
      s.st  = ($urandom_range(0, 4) == 0) && !m_done;
      s.dir = 1'($urandom);
      s.amt = C'($urandom);
      drive(s);
    end
    drive(idle());

    // Asynchronous reset mid-rotate.
    s = idle(); s.ld = 1; s.din = 16'hC3A5; drive(s);
    s = idle(); s.st = 1; s.amt = 5'd20; drive(s);
    repeat (3) drive(idle());
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("arst_acout", acout, '0);
    chk("arst_e", W'(e_out), '0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) drive(idle());
    @(posedge clk);
    #6;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
